// File: rtl/cmatrix_stream_tx.sv
// ---------------------------------------------------------------------------
// cmatrix_stream_tx
// Transmit end of the complex matrix datapath. It captures one complete N x N
// complex matrix from flat packed real/imag buses in a single-cycle load
// handshake. It then streams the elements out one per valid/ready transfer
// in row-major order, with row/column tags, a last flag and a clip flag.
//
// Optional feature macro: CMM_SAT_EN
//   defined   : each part saturates to the signed OUT_W range, out_sat flags clips
//   undefined : each part wraps to its low OUT_W bits, out_sat is tied to 0
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   load_valid / load_ready load handshake for c_real / c_imag
//   c_real, c_imag          N*N elements of IN_W bits, element k at [k*IN_W +: IN_W]
//   out_valid / out_ready   output stream handshake
//   out_real, out_imag      current element, reduced to OUT_W bits
//   out_row, out_col        row / column of current element
//   out_last                current element is the final one of the matrix
//   out_sat                 current element was clipped (real or imag)
//   busy                    matrix held, streaming in progress
// ---------------------------------------------------------------------------
module cmatrix_stream_tx #(
   parameter int N     = 4,
   parameter int IN_W  = 32,
   parameter int OUT_W = 16,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [N*N*IN_W-1:0]     c_real,
   input  logic [N*N*IN_W-1:0]     c_imag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_real,
   output logic [OUT_W-1:0]        out_imag,
   output logic [IDX_W-1:0]        out_row,
   output logic [IDX_W-1:0]        out_col,
   output logic                    out_last,
   output logic                    out_sat,
   output logic                    busy
);

   localparam int NN = N * N;
   localparam int KW = (NN > 1) ? $clog2(NN) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NN - 1);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [KW-1:0]           r_k;
   logic signed [OUT_W-1:0] r_buf_re [NN];
   logic signed [OUT_W-1:0] r_buf_im [NN];
   logic signed [OUT_W-1:0] w_red_re [NN];
   logic signed [OUT_W-1:0] w_red_im [NN];
   logic                    w_capture;
   logic                    w_xfer;
   logic                    w_send;
   logic                    w_at_last;

`ifdef CMM_SAT_EN
   logic                    r_buf_sat [NN];
   logic                    w_red_sat [NN];

   // Returns {clipped, value}. The value fits when every bit from the sign bit
   // down to bit OUT_W-1 is identical; otherwise clamp towards the sign.
   function automatic logic [OUT_W:0] f_sat(input logic signed [IN_W-1:0] x);
      logic [IN_W-OUT_W:0] top;
      top = x[IN_W-1:OUT_W-1];
      if ((&top) || !(|top))
         f_sat = {1'b0, x[OUT_W-1:0]};
      else if (x[IN_W-1])
         f_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      else
         f_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
   endfunction

   always_comb begin
      logic [OUT_W:0] t_re;
      logic [OUT_W:0] t_im;
      for (int e = 0; e < NN; e++) begin
         t_re         = f_sat(c_real[e*IN_W +: IN_W]);
         t_im         = f_sat(c_imag[e*IN_W +: IN_W]);
         w_red_re[e]  = t_re[OUT_W-1:0];
         w_red_im[e]  = t_im[OUT_W-1:0];
         w_red_sat[e] = t_re[OUT_W] | t_im[OUT_W];
      end
   end
`else
   // Wrap mode keeps only the low OUT_W bits; the upper bits are dropped.
   logic w_unused;
   assign w_unused = ^{c_real, c_imag};

   always_comb begin
      for (int e = 0; e < NN; e++) begin
         w_red_re[e] = c_real[e*IN_W +: OUT_W];
         w_red_im[e] = c_imag[e*IN_W +: OUT_W];
      end
   end
`endif

   assign w_send    = (r_state == S_SEND);
   assign w_capture = (r_state == S_IDLE) && load_valid;
   assign w_xfer    = w_send && out_ready;
   assign w_at_last = (r_k == K_LAST);

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (load_valid) w_state_nxt = S_SEND;
         S_SEND:  if (out_ready && w_at_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Element counter: returns to 0 after the final transfer, so the row/col
   // tags read 0 whenever the block is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_k <= '0;
      else if (w_capture)
         r_k <= '0;
      else if (w_xfer)
         r_k <= w_at_last ? '0 : r_k + 1'b1;
   end

   // Matrix buffer: elements are stored already reduced to OUT_W bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < NN; e++) begin
            r_buf_re[e] <= '0;
            r_buf_im[e] <= '0;
`ifdef CMM_SAT_EN
            r_buf_sat[e] <= 1'b0;
`endif
         end
      end else if (w_capture) begin
         for (int e = 0; e < NN; e++) begin
            r_buf_re[e] <= w_red_re[e];
            r_buf_im[e] <= w_red_im[e];
`ifdef CMM_SAT_EN
            r_buf_sat[e] <= w_red_sat[e];
`endif
         end
      end
   end

   // Outputs decode from registered state only.
   assign load_ready = (r_state == S_IDLE);
   assign out_valid  = w_send;
   assign busy       = w_send;
   assign out_real   = w_send ? r_buf_re[r_k] : '0;
   assign out_imag   = w_send ? r_buf_im[r_k] : '0;
   assign out_row    = IDX_W'(r_k / N);
   assign out_col    = IDX_W'(r_k % N);
   assign out_last   = w_send && w_at_last;
`ifdef CMM_SAT_EN
   assign out_sat    = w_send && r_buf_sat[r_k];
`else
   assign out_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_cmatrix_stream_tx.sv
// ---------------------------------------------------------------------------
// tb_cmatrix_stream_tx
// Self-checking bench for cmatrix_stream_tx. A queue-based model holds the
// element stream each captured matrix must produce; one compare process
// checks every output against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_cmatrix_stream_tx;

   localparam int N     = 4;
   localparam int IN_W  = 32;
   localparam int OUT_W = 16;
   localparam int IDX_W = 2;
   localparam int NN    = N * N;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 load_valid;
   logic                 load_ready;
   logic [NN*IN_W-1:0]   c_real;
   logic [NN*IN_W-1:0]   c_imag;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_W-1:0]     out_real;
   logic [OUT_W-1:0]     out_imag;
   logic [IDX_W-1:0]     out_row;
   logic [IDX_W-1:0]     out_col;
   logic                 out_last;
   logic                 out_sat;
   logic                 busy;

   cmatrix_stream_tx #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_ready(load_ready),
      .c_real(c_real), .c_imag(c_imag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_real(out_real), .out_imag(out_imag),
      .out_row(out_row), .out_col(out_col),
      .out_last(out_last), .out_sat(out_sat), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d time=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      longint re;
      longint im;
      int     row;
      int     col;
      bit     last;
      bit     sat;
   } elem_t;

   elem_t q[$];
   int    n_caps = 0;
   int    n_pops = 0;

   function automatic void red(input longint x, output longint y, output bit s);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (OUT_W - 1)) - 1;
      lo = -hi - 1;
      s  = 1'b0;
`ifdef CMM_SAT_EN
      if (x > hi) begin
         y = hi; s = 1'b1;
      end else if (x < lo) begin
         y = lo; s = 1'b1;
      end else begin
         y = x;
      end
`else
      y = x & ((longint'(1) <<< OUT_W) - 1);
      if (y > hi) y = y - (longint'(1) <<< OUT_W);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
      end else if (q.size() == 0) begin
         if (load_valid) begin
            for (int e = 0; e < NN; e++) begin
               elem_t el;
               bit    sr;
               bit    si;
               red(longint'($signed(c_real[e*IN_W +: IN_W])), el.re, sr);
               red(longint'($signed(c_imag[e*IN_W +: IN_W])), el.im, si);
               el.sat  = sr | si;
               el.row  = e / N;
               el.col  = e % N;
               el.last = (e == NN - 1);
               q.push_back(el);
            end
            n_caps++;
         end
      end else if (out_ready) begin
         void'(q.pop_front());
         n_pops++;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_load_ready", load_ready, 1);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_out_real", out_real, 0);
         chk("rst_out_imag", out_imag, 0);
         chk("rst_out_row", out_row, 0);
         chk("rst_out_col", out_col, 0);
         chk("rst_out_last", out_last, 0);
         chk("rst_out_sat", out_sat, 0);
      end else begin
         chk("load_ready", load_ready, q.size() == 0);
         chk("out_valid", out_valid, q.size() != 0);
         chk("busy", busy, q.size() != 0);
         if (q.size() != 0) begin
            chk("out_real", longint'($signed(out_real)), q[0].re);
            chk("out_imag", longint'($signed(out_imag)), q[0].im);
            chk("out_row", out_row, q[0].row);
            chk("out_col", out_col, q[0].col);
            chk("out_last", out_last, q[0].last);
            chk("out_sat", out_sat, q[0].sat);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_elem(input int e, input longint re, input longint im);
      c_real[e*IN_W +: IN_W] = re[IN_W-1:0];
      c_imag[e*IN_W +: IN_W] = im[IN_W-1:0];
   endtask

   function automatic longint rval();
      if ($urandom_range(0, 3) == 0)
         rval = longint'($signed($urandom()));
      else
         rval = longint'($urandom_range(0, 60000)) - 30000;
   endfunction

   task automatic set_rand_matrix();
      for (int e = 0; e < NN; e++) set_elem(e, rval(), rval());
   endtask

   task automatic load_wait(input int budget);
      int c0;
      c0 = n_caps;
      load_valid = 1'b1;
      for (int t = 0; t < budget; t++) begin
         @(negedge clk);
         if (n_caps != c0) break;
      end
      load_valid = 1'b0;
      chk("load_timeout", n_caps != c0, 1);
   endtask

   // mode 0: ready high, 1: pattern 1,0,0,1, 2: random. Returns DUT transfers.
   task automatic drain(input int mode, input int budget, output int xfers);
      int t;
      xfers = 0;
      for (t = 0; t < budget && q.size() != 0; t++) begin
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((t % 4) == 0) || ((t % 4) == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid && out_ready) xfers++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("drain_timeout", q.size(), 0);
   endtask

   task automatic wait_pops(input int target, input int budget);
      for (int t = 0; t < budget && n_pops < target; t++) @(negedge clk);
      chk("pop_timeout", n_pops >= target, 1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int xf;
      int p0;
      int zeros;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      out_ready  = 1'b0;
      c_real     = '0;
      c_imag     = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Sequential matrix with literal expectations
      for (int e = 0; e < NN; e++) set_elem(e, e, 100 + e);
      out_ready = 1'b1;
      load_wait(20);
      for (int k = 0; k < NN; k++) begin
         chk("t1_valid", out_valid, 1);
         chk("t1_re", longint'($signed(out_real)), k);
         chk("t1_im", longint'($signed(out_imag)), 100 + k);
         chk("t1_row", out_row, k / 4);
         chk("t1_col", out_col, k % 4);
         chk("t1_last", out_last, k == 15);
         @(negedge clk);
      end
      chk("t1_ready_after", load_ready, 1);

      // Backpressure 1,0,0,1
      set_rand_matrix();
      load_wait(20);
      drain(1, 200, xf);
      chk("t2_xfers", xf, 16);

      // Load request while streaming, at element 5
      set_rand_matrix();
      p0 = n_pops;
      load_wait(20);
      wait_pops(p0 + 5, 50);
      set_rand_matrix();
      load_valid = 1'b1;
      for (int t = 0; t < 40 && !(out_valid && out_last); t++) @(negedge clk);
      chk("t3_saw_last", out_valid && out_last, 1);
      @(negedge clk);
      chk("t3_gap_valid", out_valid, 0);
      chk("t3_gap_ready", load_ready, 1);
      @(negedge clk);
      chk("t3_recapture", out_valid, 1);
      load_valid = 1'b0;
      drain(2, 200, xf);
      chk("t3_xfers", xf, 16);

      // Width reduction on element 0
      set_rand_matrix();
      set_elem(0, 70000, -70000);
      load_wait(20);
`ifdef CMM_SAT_EN
      chk("t4_re", longint'($signed(out_real)), 32767);
      chk("t4_im", longint'($signed(out_imag)), -32768);
      chk("t4_sat", out_sat, 1);
`else
      chk("t4_re", longint'($signed(out_real)), 4464);
      chk("t4_im", longint'($signed(out_imag)), -4464);
      chk("t4_sat", out_sat, 0);
`endif
      drain(0, 40, xf);

      // Reset mid-stream at element 7
      set_rand_matrix();
      p0 = n_pops;
      load_wait(20);
      wait_pops(p0 + 7, 50);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_valid_async", out_valid, 0);
      chk("t5_ready_async", load_ready, 1);
      chk("t5_real_async", out_real, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int e = 0; e < NN; e++) set_elem(e, 200 + e, -e);
      load_wait(20);
      chk("t5_first_re", longint'($signed(out_real)), 200);
      chk("t5_first_row", out_row, 0);
      drain(2, 200, xf);
      chk("t5_xfers", xf, 16);

      // Back-to-back loads, ready high: exactly one idle cycle per matrix
      set_rand_matrix();
      out_ready = 1'b1;
      load_wait(20);
      load_valid = 1'b1;
      zeros = 0;
      for (int t = 0; t < 34; t++) begin
         if (!out_valid) zeros++;
         if (t == 10) set_rand_matrix();
         @(negedge clk);
      end
      chk("t6_bubbles", zeros, 2);
      chk("t6_streaming", out_valid, 1);
      load_valid = 1'b0;
      drain(0, 40, xf);

      // Random matrices with random backpressure
      for (int m = 0; m < 6; m++) begin
         set_rand_matrix();
         load_wait(20);
         drain(2, 300, xf);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
